// File: rtl/dehaze_pkg.sv
// rtl/dehaze_pkg.sv - shared pixel types, window geometry and min helper for the dehaze pipeline
package dehaze_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t r;
        pix_t g;
        pix_t b;
    } rgb_t;

    // Unsigned minimum of three components
    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        pix_t m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

endpackage

// File: rtl/channel_min_tree.sv
// rtl/channel_min_tree.sv - two-stage registered minimum of one 3x3 colour window
module channel_min_tree
    import dehaze_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [WIN_TAPS*PIX_W-1:0] window_i,
    output pix_t                      min_o
);

    pix_t [2:0] row_min_q;
    pix_t [2:0] row_min_d;
    pix_t       min_q;
    pix_t       min_d;

    // Row minima from the raw taps (row-major, three taps per row), then min of the row minima
    always_comb begin
        row_min_d = '0;
        for (int row = 0; row < 3; row++) begin
            row_min_d[row] = min3(window_i[PIX_W*(3*row+0) +: PIX_W],
                                  window_i[PIX_W*(3*row+1) +: PIX_W],
                                  window_i[PIX_W*(3*row+2) +: PIX_W]);
        end
        min_d = min3(row_min_q[0], row_min_q[1], row_min_q[2]);
    end

    // S1 row-minimum registers and S2 channel-minimum register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_min_q <= '0;
            min_q     <= '0;
        end else begin
            row_min_q <= row_min_d;
            min_q     <= min_d;
        end
    end

    assign min_o = min_q;

endmodule

// File: rtl/dark_channel_atm_light.sv
// rtl/dark_channel_atm_light.sv - dark-channel pipeline and per-frame atmospheric light tracker (option: ATM_BRIGHTNESS_TIEBREAK_EN)
module dark_channel_atm_light
    import dehaze_pkg::*;
#(
    parameter int FRAME_WINDOWS = 261120,
    parameter int CNT_W         = 18
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic [WIN_TAPS*PIX_W-1:0] red_window_in,
    input  logic [WIN_TAPS*PIX_W-1:0] green_window_in,
    input  logic [WIN_TAPS*PIX_W-1:0] blue_window_in,
    input  logic                      input_is_valid,
    output logic [PIX_W-1:0]          dark_pixel,
    output logic                      output_is_valid,
    output logic [PIX_W-1:0]          atm_r,
    output logic [PIX_W-1:0]          atm_g,
    output logic [PIX_W-1:0]          atm_b,
    output logic                      atm_valid,
    output logic [7:0]                frame_done_count
);

    localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(FRAME_WINDOWS - 1);
    localparam int               CTR_TAP  = WIN_TAPS / 2;

    pix_t       r_min;
    pix_t       g_min;
    pix_t       b_min;

    logic [2:0] valid_q;
    rgb_t       ctr_s1_q;
    rgb_t       ctr_s2_q;
    rgb_t       ctr_s3_q;
    rgb_t       ctr_in;
    pix_t       dark_q;
    pix_t       dark_d;

    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] win_cnt_d;
    pix_t             best_dark_q;
    pix_t             best_dark_d;
    rgb_t             best_rgb_q;
    rgb_t             best_rgb_d;
    rgb_t             atm_q;
    rgb_t             atm_d;
    logic             atm_valid_q;
    logic             atm_valid_d;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       frame_cnt_d;
    logic             first_win;
    logic             better;
    logic             take;
    logic             close;
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
    logic [9:0]       best_sum_q;
    logic [9:0]       best_sum_d;
    logic [9:0]       cur_sum;
`endif

    channel_min_tree u_red_min (
        .clk_i    (r_clk),
        .rst_ni   (r_rst),
        .window_i (red_window_in),
        .min_o    (r_min)
    );

    channel_min_tree u_green_min (
        .clk_i    (r_clk),
        .rst_ni   (r_rst),
        .window_i (green_window_in),
        .min_o    (g_min)
    );

    channel_min_tree u_blue_min (
        .clk_i    (r_clk),
        .rst_ni   (r_rst),
        .window_i (blue_window_in),
        .min_o    (b_min)
    );

    assign ctr_in.r = red_window_in[CTR_TAP*PIX_W +: PIX_W];
    assign ctr_in.g = green_window_in[CTR_TAP*PIX_W +: PIX_W];
    assign ctr_in.b = blue_window_in[CTR_TAP*PIX_W +: PIX_W];
    assign dark_d   = min3(r_min, g_min, b_min);

    // Valid shift register, centre-pixel delay line and S3 dark-channel register
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            valid_q  <= '0;
            ctr_s1_q <= '0;
            ctr_s2_q <= '0;
            ctr_s3_q <= '0;
            dark_q   <= '0;
        end else begin
            valid_q  <= {valid_q[1:0], input_is_valid};
            ctr_s1_q <= ctr_in;
            ctr_s2_q <= ctr_s1_q;
            ctr_s3_q <= ctr_s2_q;
            dark_q   <= dark_d;
        end
    end

    // Tracker: keep the brightest dark value of the frame and publish it when the frame closes
    always_comb begin
        first_win   = (win_cnt_q == '0);
        better      = (dark_q > best_dark_q);
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
        cur_sum     = {2'b00, ctr_s3_q.r} + {2'b00, ctr_s3_q.g} + {2'b00, ctr_s3_q.b};
        better      = better || ((dark_q == best_dark_q) && (cur_sum > best_sum_q));
`endif
        take        = valid_q[2] && (first_win || better);
        close       = valid_q[2] && (win_cnt_q == LAST_WIN);

        best_dark_d = take ? dark_q   : best_dark_q;
        best_rgb_d  = take ? ctr_s3_q : best_rgb_q;
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
        best_sum_d  = take ? cur_sum  : best_sum_q;
`endif
        // The close window itself may win, so the published value comes from the updated best
        atm_d       = close ? best_rgb_d : atm_q;
        atm_valid_d = close;
        frame_cnt_d = close ? frame_cnt_q + 8'd1 : frame_cnt_q;

        win_cnt_d   = win_cnt_q;
        if (valid_q[2]) begin
            win_cnt_d = close ? '0 : win_cnt_q + 1'b1;
        end
    end

    // Tracker state registers
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            win_cnt_q   <= '0;
            best_dark_q <= '0;
            best_rgb_q  <= '0;
            atm_q       <= '0;
            atm_valid_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
            best_sum_q  <= '0;
`endif
        end else begin
            win_cnt_q   <= win_cnt_d;
            best_dark_q <= best_dark_d;
            best_rgb_q  <= best_rgb_d;
            atm_q       <= atm_d;
            atm_valid_q <= atm_valid_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
            best_sum_q  <= best_sum_d;
`endif
        end
    end

    assign dark_pixel       = dark_q;
    assign output_is_valid  = valid_q[2];
    assign atm_r            = atm_q.r;
    assign atm_g            = atm_q.g;
    assign atm_b            = atm_q.b;
    assign atm_valid        = atm_valid_q;
    assign frame_done_count = frame_cnt_q;

endmodule

// File: tb/tb_dark_channel_atm_light.sv
// tb/tb_dark_channel_atm_light.sv - scoreboard bench for dark_channel_atm_light (option: ATM_BRIGHTNESS_TIEBREAK_EN)
module tb_dark_channel_atm_light;

    localparam int FW = 4;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [71:0] red_window_in;
    logic [71:0] green_window_in;
    logic [71:0] blue_window_in;
    logic        input_is_valid;
    logic [7:0]  dark_pixel;
    logic        output_is_valid;
    logic [7:0]  atm_r;
    logic [7:0]  atm_g;
    logic [7:0]  atm_b;
    logic        atm_valid;
    logic [7:0]  frame_done_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int outs   = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } dexp_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] fc;
    } aexp_t;

    dexp_t      dq[$];
    aexp_t      aq[$];
    logic [7:0] fr_dark[$];
    logic [7:0] fr_r[$];
    logic [7:0] fr_g[$];
    logic [7:0] fr_b[$];
    int         model_frames = 0;

    dark_channel_atm_light #(
        .FRAME_WINDOWS (FW),
        .CNT_W         (18)
    ) dut (
        .r_clk            (r_clk),
        .r_rst            (r_rst),
        .red_window_in    (red_window_in),
        .green_window_in  (green_window_in),
        .blue_window_in   (blue_window_in),
        .input_is_valid   (input_is_valid),
        .dark_pixel       (dark_pixel),
        .output_is_valid  (output_is_valid),
        .atm_r            (atm_r),
        .atm_g            (atm_g),
        .atm_b            (atm_b),
        .atm_valid        (atm_valid),
        .frame_done_count (frame_done_count)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: dark channel is the smallest of all 27 bytes
    function automatic logic [7:0] ref_dark(input logic [71:0] r, input logic [71:0] g, input logic [71:0] b);
        logic [7:0] m;
        m = 8'hff;
        for (int k = 0; k < 9; k++) begin
            if (r[8*k +: 8] < m) m = r[8*k +: 8];
            if (g[8*k +: 8] < m) m = g[8*k +: 8];
            if (b[8*k +: 8] < m) m = b[8*k +: 8];
        end
        return m;
    endfunction

    // Reference: pick the winning window of a finished frame
    function automatic int pick_best();
        int bi;
        bi = 0;
        for (int i = 1; i < fr_dark.size(); i++) begin
            if (fr_dark[i] > fr_dark[bi]) bi = i;
`ifdef ATM_BRIGHTNESS_TIEBREAK_EN
            else if (fr_dark[i] == fr_dark[bi] &&
                     (int'(fr_r[i]) + int'(fr_g[i]) + int'(fr_b[i])) >
                     (int'(fr_r[bi]) + int'(fr_g[bi]) + int'(fr_b[bi]))) bi = i;
`endif
        end
        return bi;
    endfunction

    // Build a window whose overall minimum is dk, with a chosen centre pixel (centre values >= dk)
    task automatic make_win(input logic [7:0] dk, input logic [7:0] cr, input logic [7:0] cg,
                            input logic [7:0] cb, output logic [71:0] r, output logic [71:0] g,
                            output logic [71:0] b);
        int ch;
        int t;
        for (int k = 0; k < 9; k++) begin
            r[8*k +: 8] = 8'($urandom_range(int'(dk), 255));
            g[8*k +: 8] = 8'($urandom_range(int'(dk), 255));
            b[8*k +: 8] = 8'($urandom_range(int'(dk), 255));
        end
        r[39:32] = cr;
        g[39:32] = cg;
        b[39:32] = cb;
        ch = $urandom_range(0, 2);
        t  = $urandom_range(0, 7);
        if (t >= 4) t++;
        if (ch == 0)      r[8*t +: 8] = dk;
        else if (ch == 1) g[8*t +: 8] = dk;
        else              b[8*t +: 8] = dk;
    endtask

    task automatic send(input logic [71:0] r, input logic [71:0] g, input logic [71:0] b);
        dexp_t de;
        aexp_t ae;
        int    bi;
        @(posedge r_clk);
        #1;
        red_window_in   = r;
        green_window_in = g;
        blue_window_in  = b;
        input_is_valid  = 1'b1;
        de.d = ref_dark(r, g, b);
        de.c = cyc;
        dq.push_back(de);
        fr_dark.push_back(de.d);
        fr_r.push_back(r[39:32]);
        fr_g.push_back(g[39:32]);
        fr_b.push_back(b[39:32]);
        if (fr_dark.size() == FW) begin
            bi = pick_best();
            model_frames = (model_frames + 1) % 256;
            ae.r  = fr_r[bi];
            ae.g  = fr_g[bi];
            ae.b  = fr_b[bi];
            ae.fc = 8'(model_frames);
            aq.push_back(ae);
            fr_dark.delete();
            fr_r.delete();
            fr_g.delete();
            fr_b.delete();
        end
    endtask

    task automatic bubble();
        @(posedge r_clk);
        #1;
        red_window_in   = {$urandom, $urandom, $urandom};
        green_window_in = {$urandom, $urandom, $urandom};
        blue_window_in  = {$urandom, $urandom, $urandom};
        input_is_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bubble();
    endtask

    // Monitor: pop and compare whenever the DUT presents a dark pixel or an atmospheric-light pulse
    always @(negedge r_clk) begin
        if (r_rst === 1'b1) begin
            if (output_is_valid) begin
                outs++;
                if (dq.size() == 0) begin
                    check("dark_unexpected", 1, 0);
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    check("dark_pixel", int'(dark_pixel), int'(e.d));
                    check("dark_latency", cyc - e.c, 3);
                end
            end
            if (atm_valid) begin
                pulses++;
                if (aq.size() == 0) begin
                    check("atm_unexpected", 1, 0);
                end else begin
                    aexp_t a;
                    a = aq.pop_front();
                    check("atm_r", int'(atm_r), int'(a.r));
                    check("atm_g", int'(atm_g), int'(a.g));
                    check("atm_b", int'(atm_b), int'(a.b));
                    check("frame_done_count", int'(frame_done_count), int'(a.fc));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        @(negedge r_clk);
        check({tag, "_dark"}, int'(dark_pixel), 0);
        check({tag, "_outv"}, int'(output_is_valid), 0);
        check({tag, "_atm"}, int'({atm_r, atm_g, atm_b}), 0);
        check({tag, "_atmv"}, int'(atm_valid), 0);
        check({tag, "_fdc"}, int'(frame_done_count), 0);
    endtask

    initial begin
        logic [71:0] wr;
        logic [71:0] wg;
        logic [71:0] wb;
        int          p0;
        int          o0;
        logic [7:0]  dk[4];
        logic [7:0]  ce[4];

        r_rst           = 1'b0;
        input_is_valid  = 1'b0;
        red_window_in   = '0;
        green_window_in = '0;
        blue_window_in  = '0;
        repeat (3) @(posedge r_clk);
        check_reset_state("reset");
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        idle(2);

        // 1: single window, minimum hidden in red tap 7
        o0 = outs;
        wr = {9{8'd200}};
        wr[63:56] = 8'd13;
        wg = {9{8'd90}};
        wb = {9{8'd150}};
        send(wr, wg, wb);
        idle(6);
        check("t1_valid_count", outs - o0, 1);
        model_frames = 0;
        fr_dark.delete(); fr_r.delete(); fr_g.delete(); fr_b.delete();
        // the lone window is a partial frame in the DUT; clear it with a reset
        @(posedge r_clk); #1; r_rst = 1'b0;
        check_reset_state("t1_rst");
        @(posedge r_clk); #1; r_rst = 1'b1;
        idle(2);

        // 2 + 4: tie at 40, then back-to-back frame of dark 0 with (9,8,7) first
        p0 = pulses;
        dk = '{8'd10, 8'd40, 8'd40, 8'd5};
        ce = '{8'd50, 8'd60, 8'd70, 8'd80};
        for (int i = 0; i < 4; i++) begin
            make_win(dk[i], ce[i], ce[i], ce[i], wr, wg, wb);
            send(wr, wg, wb);
        end
        make_win(8'd0, 8'd9, 8'd8, 8'd7, wr, wg, wb);
        send(wr, wg, wb);
        for (int i = 0; i < 3; i++) begin
            make_win(8'd0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), wr, wg, wb);
            send(wr, wg, wb);
        end
        idle(6);
        check("t2_t4_pulses", pulses - p0, 2);

        // 5: random windows with ~30% bubbles over 3 frames
        p0 = pulses;
        for (int n = 0; n < 3 * FW; ) begin
            if ($urandom_range(0, 99) < 30) begin
                bubble();
            end else begin
                for (int k = 0; k < 9; k++) begin
                    wr[8*k +: 8] = 8'($urandom_range(20, 60));
                    wg[8*k +: 8] = 8'($urandom_range(20, 60));
                    wb[8*k +: 8] = 8'($urandom_range(20, 60));
                end
                send(wr, wg, wb);
                n++;
            end
        end
        idle(6);
        check("t5_pulses", pulses - p0, 3);

        // 6: reset after 2 windows of a frame, then a clean frame
        for (int i = 0; i < 2; i++) begin
            make_win(8'd250, 8'd255, 8'd255, 8'd255, wr, wg, wb);
            send(wr, wg, wb);
        end
        idle(5);
        @(posedge r_clk); #1; r_rst = 1'b0;
        fr_dark.delete(); fr_r.delete(); fr_g.delete(); fr_b.delete();
        model_frames = 0;
        check_reset_state("t6_rst");
        @(posedge r_clk); #1; r_rst = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            make_win(8'($urandom_range(0, 100)), 8'($urandom_range(100, 255)),
                     8'($urandom_range(100, 255)), 8'($urandom_range(100, 255)), wr, wg, wb);
            send(wr, wg, wb);
        end
        idle(6);
        check("t6_pulses", pulses - p0, 1);
        check("t6_fdc", int'(frame_done_count), 1);

        check("dark_queue_drained", dq.size(), 0);
        check("atm_queue_drained", aq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
